// File: rtl/mips_hazard_unit.sv
// Load-use stall, redirect flush and EX operand forwarding control for the 5-stage MIPS pipeline.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module mips_hazard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t                state_q, state_d;
    logic [2:0]            flush_cnt_q, flush_cnt_d;

    logic                  ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;
    logic                  ex_rw_q, ex_rw_d;
    logic                  ex_load_q, ex_load_d;
    logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;

    logic                  mem_valid_q, mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
    logic                  mem_rw_q, mem_rw_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;
    logic                  wb_rw_q, wb_rw_d;

    logic                  load_use;
    logic                  in_flush;
    logic                  stall_int;
    logic                  flush_int;
    logic                  issue;
    logic                  mem_fwd_ok;
    logic                  wb_fwd_ok;
    logic [1:0]            fwd_a, fwd_b;

    always_comb begin
        load_use = 1'b0;
        if (id_valid && ex_valid_q && ex_load_q && ex_rw_q && (ex_dst_q != '0)) begin
            load_use = (id_uses_rs && (id_rs == ex_dst_q)) ||
                       (id_uses_rt && (id_rt == ex_dst_q));
        end
        in_flush  = (state_q == FLUSH);
        // A redirect or an active flush window wins over a load-use stall.
        stall_int = ~reset & load_use & ~redirect & ~in_flush;
        flush_int = ~reset & (redirect | in_flush);
        issue     = id_valid & ~stall_int & ~redirect & ~in_flush;
    end

    // Bubbles carry zeroed fields so a dead EX slot never requests forwarding.
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_dst_d    = '0;
        ex_rw_d     = 1'b0;
        ex_load_d   = 1'b0;
        ex_rs_d     = '0;
        ex_rt_d     = '0;
        if (issue) begin
            ex_valid_d = 1'b1;
            ex_dst_d   = id_dst;
            ex_rw_d    = id_reg_write;
            ex_load_d  = id_mem_read;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
        end
        mem_valid_d = ex_valid_q & ~redirect;
        mem_dst_d   = ex_dst_q;
        mem_rw_d    = ex_rw_q;
        wb_valid_d  = mem_valid_q;
        wb_dst_d    = mem_dst_q;
        wb_rw_d     = mem_rw_q;
    end

    always_comb begin
        mem_fwd_ok = mem_valid_q & mem_rw_q & (mem_dst_q != '0);
        wb_fwd_ok  = wb_valid_q & wb_rw_q & (wb_dst_q != '0);
        fwd_a      = 2'd0;
        fwd_b      = 2'd0;
        if (!reset) begin
            if (mem_fwd_ok && (mem_dst_q == ex_rs_q)) begin
                fwd_a = 2'd1;
            end else if (wb_fwd_ok && (wb_dst_q == ex_rs_q)) begin
                fwd_a = 2'd2;
            end
            if (mem_fwd_ok && (mem_dst_q == ex_rt_q)) begin
                fwd_b = 2'd1;
            end else if (wb_fwd_ok && (wb_dst_q == ex_rt_q)) begin
                fwd_b = 2'd2;
            end
        end
    end

    // With a single flush cycle the redirect cycle itself is the whole window, so RUN is kept.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN, STALL: begin
                state_d = RUN;
                if (redirect) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (stall_int) begin
                    state_d = STALL;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q <= 3'd1) begin
                    state_d     = RUN;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            ex_valid_q  <= 1'b0;
            ex_dst_q    <= '0;
            ex_rw_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_dst_q   <= '0;
            mem_rw_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_dst_q    <= '0;
            wb_rw_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ex_valid_q  <= ex_valid_d;
            ex_dst_q    <= ex_dst_d;
            ex_rw_q     <= ex_rw_d;
            ex_load_q   <= ex_load_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            mem_valid_q <= mem_valid_d;
            mem_dst_q   <= mem_dst_d;
            mem_rw_q    <= mem_rw_d;
            wb_valid_q  <= wb_valid_d;
            wb_dst_q    <= wb_dst_d;
            wb_rw_q     <= wb_rw_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_int && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (redirect && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

    assign stall       = stall_int;
    assign flush_if_id = flush_int;
    assign flush_id_ex = flush_int | stall_int;
    assign fwd_a_sel   = fwd_a;
    assign fwd_b_sel   = fwd_b;
    assign state       = state_q;

endmodule
